spi_target_sync: RTL and testbench

SPI_TARGET_SYNC -- requirements
Module: spi_target_sync

---
 rtl/spi_target_sync.sv | 193 +++++++++++++++++++
 tb/tb_spi_target_sync.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_sync.sv
// SPI mode-0 target with all inputs synchronized into the sysClk domain.
// Define SPI_TARGET_OVERRUN_EN to build the sticky overrun flag.
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysClk,
    input  logic       reset,
    input  logic       spiClk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_hist_q;
    logic                   cs_hist_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic       tx_buf_v_q, tx_buf_v_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;

    logic       tx_take;
    logic       done;
    logic       drop;
    logic [7:0] tx_next;

    // Idle levels: cs deasserted, spiClk low (mode 0), mosi low
    always_ff @(posedge sysClk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            cs_hist_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spiClk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_hist_q <= sclk_s;
            cs_hist_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign cs_rise   = cs_s & ~cs_hist_q;
    assign cs_fall   = ~cs_s & cs_hist_q;

    // An empty buffer at a load point sends zeros (underrun)
    assign tx_next = tx_buf_v_q ? tx_buf_q : 8'h00;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_buf_v_d = tx_buf_v_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        tx_take    = 1'b0;
        done       = 1'b0;
        drop       = 1'b0;

        if (cs_rise) begin
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            rx_shift_d = 7'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) state_d = LOAD;
                end
                LOAD: begin
                    tx_take    = 1'b1;
                    tx_shift_d = tx_next;
                    bit_cnt_d  = 3'd0;
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[5:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        done       = (bit_cnt_q == 3'd7);
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            tx_take    = 1'b1;
                            tx_shift_d = tx_next;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (tx_take) tx_buf_v_d = 1'b0;
        if (tx_load && !tx_buf_v_q) begin
            tx_buf_d   = tx_byte;
            tx_buf_v_d = 1'b1;
        end

        if (rx_ack) rx_valid_d = 1'b0;
        if (done) begin
            if (!rx_valid_q || rx_ack) begin
                rx_byte_d  = {rx_shift_q, mosi_s};
                rx_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_shift_q <= 7'd0;
            tx_shift_q <= 8'h00;
            tx_buf_q   <= 8'h00;
            tx_buf_v_q <= 1'b0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_buf_v_q <= tx_buf_v_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign miso     = (state_q != IDLE) & tx_shift_q[7];
    assign tx_ready = ~tx_buf_v_q;
    assign rx_byte  = rx_byte_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_TARGET_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q | drop;
    end

    always_ff @(posedge sysClk) begin
        if (reset) ovr_q <= 1'b0;
        else       ovr_q <= ovr_d;
    end

    assign overrun = ovr_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
    assign overrun     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target_sync.sv
// Randomized bench for spi_target_sync with a transaction-level model.
// Honors SPI_TARGET_OVERRUN_EN for the expected overrun behaviour.
module tb_spi_target_sync;

    localparam int SS     = 2;
    localparam int SETTLE = SS + 2;
`ifdef SPI_TARGET_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic       sysClk = 1'b0;
    logic       reset;
    logic       spiClk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ack;
    logic       overrun;

    spi_target_sync #(.SYNC_STAGES(SS)) dut (
        .sysClk  (sysClk),
        .reset   (reset),
        .spiClk  (spiClk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .tx_byte (tx_byte),
        .tx_load (tx_load),
        .tx_ready(tx_ready),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ack  (rx_ack),
        .overrun (overrun)
    );

    always #5 sysClk = ~sysClk;

    int n_chk  = 0;
    int n_pass = 0;
    bit quiet  = 1'b0;

    // Model: one-deep TX buffer, RX holding register, sticky flag
    logic [7:0] m_buf  = 8'h00;
    bit         m_buf_v;
    logic [7:0] m_rx   = 8'h00;
    bit         m_rx_v;
    bit         m_ovr;
    bit         m_miso;
    bit         m_cs   = 1'b1;

    logic [7:0] recv [4];
    logic [7:0] cap  [4];
    logic       v_at3;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge sysClk) begin
        if (quiet) begin
            chk("tx_ready", {7'd0, tx_ready}, {7'd0, !m_buf_v});
            chk("rx_valid", {7'd0, rx_valid}, {7'd0, m_rx_v});
            chk("rx_byte", rx_byte, m_rx);
            chk("overrun", {7'd0, overrun}, {7'd0, m_ovr});
            chk("miso", {7'd0, miso}, {7'd0, (m_cs ? 1'b0 : m_miso)});
        end
    end

    function automatic logic [7:0] take_slot();
        logic [7:0] s;
        s       = m_buf_v ? m_buf : 8'h00;
        m_buf_v = 1'b0;
        return s;
    endfunction

    function automatic void rx_done(input logic [7:0] b, input bit ack_now);
        if (!m_rx_v || ack_now) begin
            m_rx   = b;
            m_rx_v = 1'b1;
        end else begin
            m_ovr = m_ovr | OVR_EN;
        end
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge sysClk);
        #($urandom_range(1, 4));
    endtask

    task automatic do_reset();
        quiet   = 1'b0;
        reset   = 1'b1;
        cs      = 1'b1;
        spiClk  = 1'b0;
        mosi    = 1'b0;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        m_cs    = 1'b1;
        m_buf_v = 1'b0;
        m_rx    = 8'h00;
        m_rx_v  = 1'b0;
        m_ovr   = 1'b0;
        m_miso  = 1'b0;
        step(SETTLE + 1);
        reset = 1'b0;
        step(2);
        quiet = 1'b1;
        step(1);
    endtask

    task automatic load(input logic [7:0] b);
        quiet   = 1'b0;
        tx_byte = b;
        tx_load = 1'b1;
        if (!m_buf_v) begin
            m_buf   = b;
            m_buf_v = 1'b1;
        end
        step(1);
        tx_load = 1'b0;
        step(2);
        quiet = 1'b1;
    endtask

    task automatic ack();
        quiet  = 1'b0;
        rx_ack = 1'b1;
        m_rx_v = 1'b0;
        step(1);
        rx_ack = 1'b0;
        step(2);
        quiet = 1'b1;
    endtask

    task automatic idle_toggle();
        quiet  = 1'b0;
        spiClk = 1'b1;
        step(SETTLE);
        spiClk = 1'b0;
        step(SETTLE);
        quiet = 1'b1;
    endtask

    // Master side: data is packed MSB first, byte 0 in [31:24]
    task automatic xfer(input int nbits, input logic [31:0] data,
                        input bit ack_each, input bit ack_last,
                        input int mid_at, input logic [7:0] mid_b,
                        input bit rst_end);
        logic [7:0] cur;
        logic [7:0] rbits;
        int bi;
        int by;
        bit coinc;
        rbits  = 8'h00;
        quiet  = 1'b0;
        cs     = 1'b0;
        m_cs   = 1'b0;
        cur    = take_slot();
        m_miso = cur[7];
        step(SETTLE);
        quiet = 1'b1;
        step(2);
        for (int i = 0; i < nbits; i++) begin
            bi    = i % 8;
            by    = i / 8;
            coinc = ack_last && (bi == 7) && (by == nbits / 8 - 1);
            quiet = 1'b0;
            mosi  = data[31 - i];
            step(1);
            rbits[7 - bi] = miso;
            if (coinc) rx_ack = 1'b1;
            spiClk = 1'b1;
            if (bi == 7) begin
                rx_done(data[31 - 8 * by -: 8], coinc);
                recv[by] = rbits;
                step(SS + 1);
                rx_ack = 1'b0;
                v_at3  = rx_valid;
                step(SETTLE - SS - 1);
            end else begin
                step(SETTLE);
            end
            quiet = 1'b1;
            step(2);
            if (bi == 7 && ack_each) begin
                cap[by] = rx_byte;
                ack();
                step(1);
            end
            quiet  = 1'b0;
            spiClk = 1'b0;
            if (bi == 7) begin
                cur    = take_slot();
                m_miso = cur[7];
            end else begin
                m_miso = cur[6 - bi];
            end
            step(SETTLE);
            quiet = 1'b1;
            if (i == mid_at) load(mid_b);
            step(2);
        end
        if (rst_end) begin
            do_reset();
        end else begin
            quiet  = 1'b0;
            cs     = 1'b1;
            m_cs   = 1'b1;
            m_miso = 1'b0;
            step(SETTLE);
            quiet = 1'b1;
            step(2);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int op;

    initial begin
        reset   = 1'b1;
        cs      = 1'b1;
        spiClk  = 1'b0;
        mosi    = 1'b0;
        tx_byte = 8'h00;
        tx_load = 1'b0;
        rx_ack  = 1'b0;
        v_at3   = 1'b0;
        do_reset();

        chk("rst_tx_ready", {7'd0, tx_ready}, 8'h01);
        chk("rst_rx_valid", {7'd0, rx_valid}, 8'h00);
        chk("rst_rx_byte", rx_byte, 8'h00);
        chk("rst_overrun", {7'd0, overrun}, 8'h00);
        chk("rst_miso", {7'd0, miso}, 8'h00);

        // Basic byte exchange
        load(8'h3C);
        xfer(8, 32'hA500_0000, 0, 0, -1, 8'h00, 0);
        chk("a5_master_rx", recv[0], 8'h3C);
        chk("a5_valid_by3", {7'd0, v_at3}, 8'h01);
        chk("a5_rx_byte", rx_byte, 8'hA5);
        ack();

        // Back-to-back bytes under one cs, reload mid-transfer
        load(8'h11);
        xfer(16, 32'h0102_0000, 1, 0, 2, 8'h22, 0);
        chk("b2b_rx0", recv[0], 8'h11);
        chk("b2b_rx1", recv[1], 8'h22);
        chk("b2b_cap0", cap[0], 8'h01);
        chk("b2b_cap1", cap[1], 8'h02);

        // tx_load while full is ignored
        load(8'h12);
        load(8'h34);
        chk("full_ready", {7'd0, tx_ready}, 8'h00);
        xfer(8, 32'h0000_0000, 0, 0, -1, 8'h00, 0);
        chk("full_ignored", recv[0], 8'h12);

        // Ack coinciding with completion stores the new byte
        xfer(8, 32'h9900_0000, 0, 1, -1, 8'h00, 0);
        chk("coinc_byte", rx_byte, 8'h99);
        chk("coinc_ovr", {7'd0, overrun}, 8'h00);
        ack();

        // Underrun: nothing loaded
        xfer(8, 32'h5A00_0000, 0, 0, -1, 8'h00, 0);
        chk("under_miso", recv[0], 8'h00);
        chk("under_ready", {7'd0, tx_ready}, 8'h01);
        ack();

        // Overrun: second byte dropped
        xfer(8, 32'h5500_0000, 0, 0, -1, 8'h00, 0);
        xfer(8, 32'hAA00_0000, 0, 0, -1, 8'h00, 0);
        chk("ovr_byte", rx_byte, 8'h55);
        chk("ovr_flag", {7'd0, overrun}, {7'd0, OVR_EN});
        ack();

        // Spiclk activity with cs high changes nothing
        idle_toggle();
        idle_toggle();
        chk("idle_valid", {7'd0, rx_valid}, 8'h00);

        // Partial byte is discarded on cs rise
        xfer(5, 32'hF800_0000, 0, 0, -1, 8'h00, 0);
        chk("part_valid", {7'd0, rx_valid}, 8'h00);
        xfer(8, 32'hC300_0000, 0, 0, -1, 8'h00, 0);
        chk("part_next", rx_byte, 8'hC3);

        // Reset mid-transfer, then a clean byte
        xfer(4, 32'hF000_0000, 0, 0, 1, 8'h77, 1);
        chk("mrst_ready", {7'd0, tx_ready}, 8'h01);
        chk("mrst_valid", {7'd0, rx_valid}, 8'h00);
        chk("mrst_byte", rx_byte, 8'h00);
        chk("mrst_ovr", {7'd0, overrun}, 8'h00);
        chk("mrst_miso", {7'd0, miso}, 8'h00);
        xfer(8, 32'h0F00_0000, 0, 0, -1, 8'h00, 0);
        chk("mrst_next", rx_byte, 8'h0F);

        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 4));
            case (op)
                0: load(8'($urandom));
                1: ack();
                2: xfer(8 * int'($urandom_range(1, 3)), $urandom,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 10)) - 1, 8'($urandom), 0);
                3: xfer(int'($urandom_range(1, 20)), $urandom,
                        0, 0, -1, 8'h00, 0);
                default: idle_toggle();
            endcase
        end

        quiet = 1'b0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
